// File: rtl/keypad_scan_ctrl_if.sv
// Key handoff between the keypad scanner (master) and the key consumer (slave).
interface keypad_scan_ctrl_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       overflow;

  modport master (output key_code, key_valid, overflow, input key_ack);
  modport slave  (input key_code, key_valid, overflow, output key_ack);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with press/release debounce and a one-entry key register.
// Define KEYPAD_FIFO_EN to replace the key register with a 4-entry FIFO.
module keypad_scan_ctrl #(
  parameter logic [19:0] SCAN_CNT_MAX     = 20'd5,
  parameter logic [19:0] DEBOUNCE_CNT_MAX = 20'd8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [3:0]         row_n,
  input  logic [3:0]         col_n,
  keypad_scan_ctrl_if.master kif
);
  typedef enum logic [1:0] {SCAN, PRESS_DB, HOLD, RELEASE_DB} state_e;

  state_e      state_q, state_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [19:0] scan_cnt_q, scan_cnt_d, db_cnt_q, db_cnt_d;
  logic [3:0]  col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic [3:0]  lat_col_q, lat_col_d, key_lat_q, key_lat_d, row_n_q, row_n_d;
  logic        ovf_q, ovf_d;
  logic        push, one_low;
  logic [1:0]  col_idx;
  logic [3:0]  col;

  assign col_s1_d = col_n;
  assign col_s2_d = col_s1_q;
  assign col      = col_s2_q;

  // A press counts only when exactly one column is pulled low.
  always_comb begin
    one_low = 1'b1;
    col_idx = 2'd0;
    case (col)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    scan_cnt_d = scan_cnt_q;
    db_cnt_d   = db_cnt_q;
    lat_col_d  = lat_col_q;
    key_lat_d  = key_lat_q;
    push       = 1'b0;
    case (state_q)
      SCAN:
        if (scan_cnt_q == SCAN_CNT_MAX - 20'd1) begin
          scan_cnt_d = '0;
          if (one_low) begin
            lat_col_d = col;
            key_lat_d = {row_idx_q, col_idx};
            db_cnt_d  = '0;
            state_d   = PRESS_DB;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 20'd1;
        end
      PRESS_DB:
        if (col != lat_col_q) begin
          state_d    = SCAN;
          row_idx_d  = row_idx_q + 2'd1;
          scan_cnt_d = '0;
        end else if (db_cnt_q == DEBOUNCE_CNT_MAX - 20'd1) begin
          push    = 1'b1;
          state_d = HOLD;
        end else begin
          db_cnt_d = db_cnt_q + 20'd1;
        end
      HOLD:
        if (col == 4'hf) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end
      RELEASE_DB:
        if (col != 4'hf) begin
          state_d = HOLD;
        end else if (db_cnt_q == DEBOUNCE_CNT_MAX - 20'd1) begin
          state_d    = SCAN;
          row_idx_d  = row_idx_q + 2'd1;
          scan_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 20'd1;
        end
      default: state_d = SCAN;
    endcase
    row_n_d = ~(4'b0001 << row_idx_d);
  end

`ifdef KEYPAD_FIFO_EN
  logic [3:0][3:0] mem_q, mem_d;
  logic [1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            pop, push_ok;

  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop      = kif.key_ack && (cnt_q != 3'd0);
    push_ok  = push && ((cnt_q != 3'd4) || pop);
    ovf_d    = push && !push_ok;
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    if (push_ok) begin
      mem_d[wr_ptr_q] = key_lat_q;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    cnt_d = cnt_q + {2'b00, push_ok} - {2'b00, pop};
  end

  assign kif.key_valid = (cnt_q != 3'd0);
  assign kif.key_code  = mem_q[rd_ptr_q];
`else
  logic       kv_q, kv_d;
  logic [3:0] kc_q, kc_d;

  always_comb begin
    kv_d  = kv_q;
    kc_d  = kc_q;
    ovf_d = 1'b0;
    if (push) begin
      if (!kv_q || kif.key_ack) begin
        kc_d = key_lat_q;
        kv_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (kv_q && kif.key_ack) begin
      kv_d = 1'b0;
    end
  end

  assign kif.key_valid = kv_q;
  assign kif.key_code  = kc_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q   <= 4'hf;
      col_s2_q   <= 4'hf;
      state_q    <= SCAN;
      row_idx_q  <= '0;
      scan_cnt_q <= '0;
      db_cnt_q   <= '0;
      lat_col_q  <= 4'hf;
      key_lat_q  <= '0;
      row_n_q    <= 4'hf;
      ovf_q      <= 1'b0;
`ifdef KEYPAD_FIFO_EN
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
`else
      kv_q       <= 1'b0;
      kc_q       <= '0;
`endif
    end else begin
      col_s1_q   <= col_s1_d;
      col_s2_q   <= col_s2_d;
      state_q    <= state_d;
      row_idx_q  <= row_idx_d;
      scan_cnt_q <= scan_cnt_d;
      db_cnt_q   <= db_cnt_d;
      lat_col_q  <= lat_col_d;
      key_lat_q  <= key_lat_d;
      row_n_q    <= row_n_d;
      ovf_q      <= ovf_d;
`ifdef KEYPAD_FIFO_EN
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
`else
      kv_q       <= kv_d;
      kc_q       <= kc_d;
`endif
    end
  end

  assign row_n        = row_n_q;
  assign kif.overflow = ovf_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: procedural keypad/scan model compared every cycle, plus literal checkpoints.
module tb_keypad_scan_ctrl;
  localparam int SCAN = 5;
  localparam int DB   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n, col_n;
  keypad_scan_ctrl_if kif();

  keypad_scan_ctrl #(.SCAN_CNT_MAX(20'd5), .DEBOUNCE_CNT_MAX(20'd8)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .kif(kif)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed switch pulls its column low while its row is driven.
  bit         pressed = 0;
  int         prow = 0, pcol = 0;
  bit         ovr_en = 0;
  logic [3:0] ovr_val = 4'hf;
  always_comb
    col_n = ovr_en ? ovr_val : ((pressed && !row_n[prow]) ? ~(4'b0001 << pcol) : 4'hf);

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [3:0] m_row_n, m_kc, sp1, sp2, col_neg;
  logic       m_kv, m_ovf;
  bit         m_rst, m_in_press;
  logic [3:0] mq[$];

  function automatic logic [1:0] zero_pos(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (!c[i]) return i[1:0];
    return 2'd0;
  endfunction

  task automatic mreset();
    sp1 = 4'hf; sp2 = 4'hf; m_kv = 0; m_kc = 4'h0; m_ovf = 0; m_row_n = 4'hf;
    mq.delete();
  endtask

  // One clock edge: key buffer, row drive and the two-stage view of the columns.
  task automatic tick(input bit push, input logic [3:0] code, input int nrow);
    bit pop;
    @(posedge clk);
    m_ovf = 0;
    if (rst) begin
      while (rst) begin mreset(); @(posedge clk); end
      m_rst = 1; push = 0; nrow = 0;
    end
`ifdef KEYPAD_FIFO_EN
    pop = kif.key_ack && (mq.size() != 0);
    if (push && mq.size() == 4 && !pop) m_ovf = 1;
    if (pop) void'(mq.pop_front());
    if (push && !m_ovf) mq.push_back(code);
    m_kv = (mq.size() != 0);
    if (m_kv) m_kc = mq[0];
`else
    pop = 0;
    if (push) begin
      if (!m_kv || kif.key_ack) begin m_kc = code; m_kv = 1; end
      else m_ovf = 1;
    end else if (m_kv && kif.key_ack) m_kv = 0;
`endif
    m_row_n = ~(4'b0001 << nrow);
    sp2 = sp1; sp1 = col_neg;
  endtask

  initial begin : model
    int row, k, run;
    bit ok;
    logic [3:0] c, lat, code;
    mreset();
    m_in_press = 0;
    tick(0, 4'h0, 0);
    forever begin
      m_rst = 0; row = 0; k = 1;
      while (!m_rst) begin
        c = sp2;
        if (k < SCAN - 1) begin k++; tick(0, 4'h0, row); continue; end
        k = 0;
        if ($countones(~c) != 1) begin row = (row + 1) % 4; tick(0, 4'h0, row); continue; end
        lat = c; code = {row[1:0], zero_pos(c)};
        m_in_press = 1; tick(0, 4'h0, row);
        run = 0; ok = 0;
        while (!m_rst) begin
          c = sp2;
          if (c != lat) begin row = (row + 1) % 4; tick(0, 4'h0, row); break; end
          run++;
          if (run == DB) begin ok = 1; tick(1, code, row); break; end
          tick(0, 4'h0, row);
        end
        m_in_press = 0;
        if (!ok) continue;
        // released once the columns read idle DB+1 edges in a row
        run = 0;
        while (!m_rst) begin
          run = (sp2 == 4'hf) ? run + 1 : 0;
          if (run == DB + 1) begin row = (row + 1) % 4; tick(0, 4'h0, row); break; end
          tick(0, 4'h0, row);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int         ovf_cnt = 0, kv_cycles = 0, row_chg = 0;
  logic [3:0] prev_row_n = 4'hf;
  always @(negedge clk) begin
    col_neg = col_n;
    if (kif.overflow) ovf_cnt++;
    if (kif.key_valid) kv_cycles++;
    if (row_n != prev_row_n) row_chg++;
    prev_row_n = row_n;
    if (rst) begin
      chk("rst_row_n", row_n, 4'hf);
      chk("rst_key_valid", kif.key_valid, 1'b0);
      chk("rst_overflow", kif.overflow, 1'b0);
      chk("rst_key_code", kif.key_code, 4'h0);
    end else begin
      chk("row_n", row_n, m_row_n);
      chk("key_valid", kif.key_valid, m_kv);
      chk("overflow", kif.overflow, m_ovf);
`ifdef KEYPAD_FIFO_EN
      if (m_kv) chk("key_code", kif.key_code, m_kc);
`else
      chk("key_code", kif.key_code, m_kc);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int r, input int c);
    pressed = 1; prow = r; pcol = c;
    cyc(40);
    pressed = 0;
    cyc(20);
  endtask

  task automatic ack1();
    kif.key_ack = 1; cyc(1); kif.key_ack = 0;
  endtask

  initial begin
    int base_ovf, base_kv, base_chg, t;
    kif.key_ack = 0;
    cyc(3);
    chk("lit_rst_row_n", row_n, 4'hf);
    chk("lit_rst_kv", kif.key_valid, 1'b0);
    rst = 0;
    cyc(1); chk("lit_first_row", row_n, 4'b1110);
    cyc(3); chk("lit_row0_dwell", row_n, 4'b1110);
    cyc(1); chk("lit_row1", row_n, 4'b1101);

    // row 2 col 1 held 40 cycles -> one key 9
    base_ovf = ovf_cnt;
    pressed = 1; prow = 2; pcol = 1;
    cyc(40);
    chk("lit_key9_valid", kif.key_valid, 1'b1);
    chk("lit_key9_code", kif.key_code, 4'h9);
    pressed = 0; cyc(20);
    chk("lit_key9_still", kif.key_valid, 1'b1);
    chk("lit_key9_noovf", ovf_cnt - base_ovf, 0);
    ack1();
    chk("lit_ack_clears", kif.key_valid, 1'b0);
    ack1();
    chk("lit_ack_ignored", kif.key_valid, 1'b0);

    // bounce during press debounce on row 1
    base_kv = kv_cycles;
    pressed = 1; prow = 1; pcol = 2;
    t = 0;
    while (!m_in_press && t < 100) begin cyc(1); t++; end
    chk("lit_bounce_reached", t < 100, 1'b1);
    cyc(3); pressed = 0;
    cyc(5);
    chk("lit_bounce_next_row", row_n, 4'b1011);
    cyc(40);
    chk("lit_bounce_nokey", kv_cycles - base_kv, 0);

    // two columns low: ghost rejected, rows keep rotating
    base_kv = kv_cycles; base_chg = row_chg;
    ovr_en = 1; ovr_val = 4'b1100;
    cyc(60);
    ovr_en = 0; cyc(10);
    chk("lit_ghost_nokey", kv_cycles - base_kv, 0);
    chk("lit_ghost_rotates", row_chg - base_chg >= 10, 1'b1);

`ifdef KEYPAD_FIFO_EN
    base_ovf = ovf_cnt;
    press(0, 0); press(0, 1); press(0, 2); press(0, 3); press(1, 0);
    chk("lit_fifo_ovf", ovf_cnt - base_ovf, 1);
    for (int i = 0; i < 4; i++) begin
      chk("lit_fifo_order", kif.key_code, i);
      ack1();
    end
    chk("lit_fifo_empty", kif.key_valid, 1'b0);
`else
    base_ovf = ovf_cnt;
    press(0, 3); press(3, 2);
    chk("lit_drop_ovf", ovf_cnt - base_ovf, 1);
    chk("lit_drop_kept", kif.key_code, 4'h3);
    chk("lit_drop_valid", kif.key_valid, 1'b1);
    ack1();
    chk("lit_drop_acked", kif.key_valid, 1'b0);
`endif

    // reset while a key is held: buffer discarded, key found again
    pressed = 1; prow = 1; pcol = 1;
    cyc(40);
    chk("lit_pre_rst_key", kif.key_valid, 1'b1);
    rst = 1; cyc(2);
    chk("lit_mid_rst_kv", kif.key_valid, 1'b0);
    chk("lit_mid_rst_row", row_n, 4'hf);
    rst = 0;
    cyc(40);
    chk("lit_redetect_kv", kif.key_valid, 1'b1);
    chk("lit_redetect_code", kif.key_code, 4'h5);
    pressed = 0; cyc(20);
    ack1(); cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_CNT_MAX, default 20'd5 (silicon: 20'd200_000); meaning: clk cycles each row is driven per scan step.
REQ-002 Parameter DEBOUNCE_CNT_MAX, default 20'd8; meaning: consecutive stable clk cycles needed to accept a press or release.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 row_n  output  4  keypad row drive, active-low, exactly one bit low outside reset.
REQ-006 col_n  input  4  keypad column sense, active-low, externally pulled up, asynchronous.
REQ-007 key_code  output  4  accepted key, {row index[1:0], col index[1:0]}.
REQ-008 key_valid  output  1  key_code holds an unconsumed key.
REQ-009 key_ack  input  1  consumer takes key_code in the cycle key_valid && key_ack.
REQ-010 overflow  output  1  one-cycle pulse when an accepted key is dropped.

Function
REQ-011 col_n SHALL pass a 2-FF synchronizer; all decisions use synchronized col (2-cycle latency).
REQ-012 States SHALL be SCAN, PRESS_DB, HOLD, RELEASE_DB.
REQ-013 SCAN: row_n = ~(4'b1 << row_idx); dwell counter 0..SCAN_CNT_MAX-1; col sampled only at count SCAN_CNT_MAX-1.
REQ-014 SCAN sample with col == 4'hf: row_idx increments, 3 wraps to 0, dwell counter restarts.
REQ-015 SCAN sample with exactly one col bit low: latch row_idx and col index, clear debounce counter, enter PRESS_DB; row_n unchanged.
REQ-016 SCAN sample with two or more col bits low: treated as no press, row_idx advances (ghost/multi-key rejection).
REQ-017 PRESS_DB: counter increments each cycle col equals latched pattern; any mismatch -> SCAN with row_idx advanced, no key emitted.
REQ-018 PRESS_DB counter reaching DEBOUNCE_CNT_MAX-1 with match: key accepted (push, REQ-021), enter HOLD; exactly one key per physical press.
REQ-019 HOLD: row_n held; first cycle col == 4'hf -> RELEASE_DB with counter cleared.
REQ-020 RELEASE_DB: col == 4'hf for DEBOUNCE_CNT_MAX consecutive cycles -> SCAN, row_idx advanced; any low col bit -> back to HOLD.
REQ-021 Push without buffer: if !key_valid or key_ack in same cycle, load key_code and set key_valid next cycle; else drop key, overflow = 1 for one cycle.
REQ-022 key_valid && key_ack with no push: key_valid clears next cycle; key_code retains last value.
REQ-023 key_code SHALL be stable while key_valid is high.
REQ-024 key_ack while key_valid low SHALL be ignored.

Reset
REQ-025 On rst: state SCAN, row_idx 0, all counters 0, synchronizer FFs 4'hf, buffer empty.
REQ-026 Reset outputs: row_n = 4'hf, key_code = 4'h0, key_valid = 0, overflow = 0.
REQ-027 First cycle after rst release SHALL drive row_n = 4'b1110.
REQ-028 rst mid-debounce or mid-hold SHALL discard the pending key; still-held key re-detected from SCAN.

Configuration
REQ-029 Macro KEYPAD_FIFO_EN; when defined, output register replaced by a 4-entry FIFO.
REQ-030 With KEYPAD_FIFO_EN: key_valid = !empty; key_code = head entry; ack pops; push when full drops key, pulses overflow; push and pop in same cycle when full SHALL succeed without overflow.
REQ-031 Without KEYPAD_FIFO_EN: single-entry behaviour of REQ-021/022 exactly; no FIFO storage synthesized.

Verification
REQ-032 Reset: rst high -> row_n = 4'hf, key_valid = 0; release -> row_n = 4'b1110, then 4'b1101 after 5 cycles with col_n = 4'hf.
REQ-033 Press key row 2 col 1 (col_n = 4'b1101 while row_n = 4'b1011) held 40 cycles -> one key_code = 4'h9, key_valid until key_ack, no second key.
REQ-034 Bounce: col_n low 3 cycles then high during PRESS_DB -> no key_valid, scan resumes at next row.
REQ-035 Two columns low (col_n = 4'b1100) -> no key ever accepted, row_n keeps rotating.
REQ-036 Without FIFO: two presses, key_ack held low -> first key retained, overflow pulses once on second.
REQ-037 With KEYPAD_FIFO_EN: five presses (codes 0,1,2,3,4), no ack -> overflow on fifth; acks return 0,1,2,3 in order.
